// File: rtl/edge_pkg.sv
// Shared types and helpers for the 3x3 gradient edge-detection blocks.
package edge_pkg;

  typedef enum logic {
    MODE_PREWITT = 1'b0,
    MODE_SOBEL   = 1'b1
  } grad_mode_e;

  // Signed gradient width: enough headroom for a Sobel sum of four full-scale taps.
  function automatic int unsigned grad_w(input int unsigned data_w);
    return data_w + 3;
  endfunction

  // Clamp an unsigned magnitude to the largest data_w-bit pixel value.
  function automatic logic [31:0] saturate(input logic [31:0] mag, input int unsigned data_w);
    logic [31:0] max_v;
    max_v = (32'd1 << data_w) - 32'd1;
    return (mag > max_v) ? max_v : mag;
  endfunction

endpackage

// File: rtl/grad_kernel_3x3.sv
// Combinational Prewitt/Sobel 3x3 gradient kernel; pXY = row X (0 = top), column Y (0 = left).
module grad_kernel_3x3
  import edge_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0]        p00,
  input  logic [DATA_W-1:0]        p01,
  input  logic [DATA_W-1:0]        p02,
  input  logic [DATA_W-1:0]        p10,
  input  logic [DATA_W-1:0]        p11,
  input  logic [DATA_W-1:0]        p12,
  input  logic [DATA_W-1:0]        p20,
  input  logic [DATA_W-1:0]        p21,
  input  logic [DATA_W-1:0]        p22,
  input  logic                     mode,
  output logic signed [DATA_W+2:0] gx,
  output logic signed [DATA_W+2:0] gy
);

  localparam int unsigned GW = grad_w(DATA_W);

  typedef logic signed [GW-1:0] sgrad_t;

  function automatic sgrad_t ext(input logic [DATA_W-1:0] p);
    return sgrad_t'({3'b000, p});
  endfunction

  // Centre tap carries no weight in either kernel.
  logic unused_center;
  assign unused_center = ^p11;

  sgrad_t k01, k10, k12, k21;

  // Middle-tap weighting (x1 Prewitt, x2 Sobel) followed by the two difference sums.
  always_comb begin
    k01 = ext(p01);
    k10 = ext(p10);
    k12 = ext(p12);
    k21 = ext(p21);
    if (grad_mode_e'(mode) == MODE_SOBEL) begin
      k01 = k01 <<< 1;
      k10 = k10 <<< 1;
      k12 = k12 <<< 1;
      k21 = k21 <<< 1;
    end
    gx = (ext(p02) + k12 + ext(p22)) - (ext(p00) + k10 + ext(p20));
    gy = (ext(p20) + k21 + ext(p22)) - (ext(p00) + k01 + ext(p02));
  end

endmodule

// File: rtl/edge_grad_3x3.sv
// Streaming 3x3 gradient edge detector: window, column tagging, per-line mode/threshold
// latch and a two-stage pipeline producing saturated |GX|+|GY| and an edge flag.
module edge_grad_3x3
  import edge_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned COL_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sol_in,
  input  logic [DATA_W-1:0] din_top,
  input  logic [DATA_W-1:0] din_mid,
  input  logic [DATA_W-1:0] din_bot,
  input  logic              mode,
  input  logic [DATA_W-1:0] thresh,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout,
  output logic              edge_out
);

  localparam int unsigned GW = grad_w(DATA_W);

  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W-1:0] din_r [3];

  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_tag;
  logic              border;
  grad_mode_e        mode_lat;
  logic [DATA_W-1:0] thr_lat;

  logic signed [GW-1:0] gx, gy;
  logic signed [GW-1:0] s1_gx, s1_gy;
  logic                 s1_valid;
  logic                 s1_border;
  logic [DATA_W-1:0]    s1_thr;

  logic [GW-1:0]     abs_x, abs_y, mag;
  logic [DATA_W-1:0] sat;

  assign din_r[0] = din_top;
  assign din_r[1] = din_mid;
  assign din_r[2] = din_bot;

  assign col_tag = sol_in ? '0 : col;
  assign border  = (col_tag < COL_W'(2));

  // The kernel sees the window as it will be after this pixel shifts in, so the
  // result registers in the same cycle as the window update (centre = column c-1).
  grad_kernel_3x3 #(
    .DATA_W(DATA_W)
  ) u_kernel (
    .p00 (win[0][1]),
    .p01 (win[0][2]),
    .p02 (din_top),
    .p10 (win[1][1]),
    .p11 (win[1][2]),
    .p12 (din_mid),
    .p20 (win[2][1]),
    .p21 (win[2][2]),
    .p22 (din_bot),
    .mode(mode_lat),
    .gx  (gx),
    .gy  (gy)
  );

  // 3x3 window shift register, advancing only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (valid_in) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= din_r[r];
      end
    end
  end

  // Column counter with start-of-line resync; mode/threshold captured at column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      mode_lat <= MODE_PREWITT;
      thr_lat  <= '0;
    end else if (valid_in) begin
      if (sol_in) begin
        col <= COL_W'(1);
      end else if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
      end else begin
        col <= col + COL_W'(1);
      end
      if (col_tag == '0) begin
        mode_lat <= grad_mode_e'(mode);
        thr_lat  <= thresh;
      end
    end
  end

  // Stage 1: gradients, border tag and the threshold in force for this pixel's line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_border <= 1'b0;
      s1_thr    <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_gx     <= gx;
        s1_gy     <= gy;
        s1_border <= border;
        s1_thr    <= thr_lat;
      end
    end
  end

  // Full-width absolute values and sum, then clamp to the pixel range.
  always_comb begin
    abs_x = s1_gx[GW-1] ? unsigned'(-s1_gx) : unsigned'(s1_gx);
    abs_y = s1_gy[GW-1] ? unsigned'(-s1_gy) : unsigned'(s1_gy);
    mag   = abs_x + abs_y;
    sat   = DATA_W'(saturate(32'(mag), DATA_W));
  end

  // Stage 2: registered magnitude and edge flag; both hold between valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      dout      <= '0;
      edge_out  <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        if (s1_border) begin
          dout     <= '0;
          edge_out <= 1'b0;
        end else begin
          dout     <= sat;
          edge_out <= (sat >= s1_thr);
        end
      end
    end
  end

endmodule

// File: doc/edge_grad_3x3.md
Name: edge_grad_3x3

Overview:
Parametrised 3x3 gradient edge detector for the streaming image pipeline. It sits after the line buffer, which supplies three vertically aligned pixels per clock (top, middle and bottom rows). The block builds a 3x3 window and computes signed GX and GY using either the Prewitt or the Sobel kernel. It then outputs a saturated magnitude |GX|+|GY| and a thresholded edge flag, with fixed latency and raster-preserving border handling.

Parameters:
DATA_W, 8, pixel bit width (unsigned grey level)
IMG_W, 640, active pixels per line
COL_W, 10, column counter width; must satisfy 2^COL_W >= IMG_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
valid_in  in  1  qualifies din_top/din_mid/din_bot for one pixel
sol_in  in  1  start-of-line; high with the first valid_in of each line
din_top  in  DATA_W  row y-1 pixel
din_mid  in  DATA_W  row y pixel
din_bot  in  DATA_W  row y+1 pixel
mode  in  1  0 = Prewitt, 1 = Sobel
thresh  in  DATA_W  edge threshold
valid_out  out  1  qualifies dout/edge_out
dout  out  DATA_W  saturated gradient magnitude
edge_out  out  1  1 when dout >= latched threshold

Behaviour:
- Reset (async, rst_n low): all window registers, col counter, pipeline registers, valid_out, dout, edge_out = 0; latched mode = 0 (Prewitt); latched threshold = 0.
- Window: shifts only on valid_in. w[r][2] <= din_r, w[r][1] <= w[r][2], w[r][0] <= w[r][1]. Column 0 is the oldest (left), column 2 the newest (right). No shift and no state change when valid_in is low.
- Column counter col: on valid_in with sol_in, col <= 1. Otherwise, on valid_in, col <= col+1, wrapping to 0 after IMG_W-1.
  - The value tagged onto a pixel is the count before the update: 0 if sol_in.
  - sol_in overrides any count, so it resynchronises after dropped pixels.
- Mode/threshold latch: mode and thresh are sampled on valid_in with sol_in, or with tagged col==0. They are held for the whole line; mid-line changes take effect at the next line.
- Kernel (weights k = 1 for Prewitt, 2 for Sobel, applied to the middle tap):
  - GX = (w0[2] + k*w1[2] + w2[2]) - (w0[0] + k*w1[0] + w2[0])
  - GY = (w2[0] + k*w2[1] + w2[2]) - (w0[0] + k*w0[1] + w0[2])
  - Row 0 = top; no other taps contribute.
  - GX and GY are signed, DATA_W+3 bits, computed from zero-extended pixels. No truncation is allowed before the absolute value.
- Magnitude: mag = |GX| + |GY|, unsigned DATA_W+3 bits. dout = (mag > 2^DATA_W-1) ? 2^DATA_W-1 : mag[DATA_W-1:0].
- Edge flag: edge_out = (dout >= latched thresh).
- Pipeline:
  - Stage 1 registers GX, GY and a border tag on valid_in.
  - Stage 2 registers dout and edge_out.
  - The valid bit propagates every cycle.
  - valid_out is asserted exactly 2 cycles after each valid_in, one-for-one, with no bubbles added.
  - Throughput is 1 pixel/clock; there is no backpressure.
- Border handling: the pixel whose tagged col is 0 or 1 (incomplete window) still produces valid_out, with dout = 0 and edge_out = 0. Each line therefore outputs exactly IMG_W results.
  - Output for tagged col c (c >= 2) corresponds to the window centred at column c-1. Alignment is a fixed 1-pixel shift, documented for downstream.
- Gaps: valid_in may drop for any number of cycles, and the window holds. valid_out for pixels already in flight still appears 2 cycles after their valid_in. dout and edge_out hold their last value when valid_out is low.
- Reset mid-line: everything clears. The first pixel after reset is treated as col 0 unless sol_in is absent and counting continues from 0 regardless.

Decomposition:
- Shared package edge_pkg:
  - MODE_PREWITT = 1'b0, MODE_SOBEL = 1'b1
  - function grad_w(DATA_W) = DATA_W+3
  - saturate function
- One sub-module, grad_kernel_3x3: combinational; nine pixels plus mode in, signed GX/GY out. It is reused by later direction-estimation blocks.
- Top level holds the window, counter, latches and pipeline.

Test Plan:
- Flat field: all pixels 100, IMG_W=8, Prewitt -> 8 valid_out per line; dout=0 everywhere, edge_out=0.
- Vertical step, DATA_W=8: left columns 0, right columns 200, Prewitt -> GX=600, dout saturates to 255; same step with values 0/50 -> dout=150 (Prewitt), 200 (Sobel).
- Horizontal step: top row 10, mid 10, bottom 40, Sobel -> GY=120, GX=0, dout=120. With thresh=120 -> edge_out=1; thresh=121 -> edge_out=0.
- Negative gradient: left 200, right 150, Prewitt -> GX=-150, dout=150, confirming the absolute value and sign width.
- Border and latency: random stream -> cols 0 and 1 give dout=0, and valid_out is exactly 2 cycles after each valid_in. valid_in toggled 1-0-0-1 -> matching gaps in valid_out, with window contents unaffected.
- Mode and reset: toggle mode mid-line -> result changes only from the next sol_in. Assert rst_n low mid-line -> all outputs 0 asynchronously, mode returns to Prewitt, and the next sol_in restarts col at 0.
